window_reader: RTL and testbench

WINDOW_READER -- requirements
Module: window_reader

---
 rtl/window_reader.sv | 100 ++++++++++
 tb/tb_window_reader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/window_reader.sv
// window_reader: sliding-window read sequencer over a circular row buffer.
// Waits until enough rows are buffered, streams win_len row addresses starting
// at base (stalling on backpressure), then frees stride rows with a release pulse
// and slides base forward by stride.
// Ports:
//   clk, rst (async, active-low)
//   i_start        one-cycle request to begin (honoured only when idle)
//   i_stop         finish after the current window (latched while busy)
//   i_win_len      rows per window
//   i_stride       rows freed after each window
//   i_valid_count  rows held in the buffer (writer-side count)
//   i_read_ready   downstream accepts the current beat
//   o_rd_addr      row address of the current beat, qualified by o_rd_valid
//   o_start_row_addr/o_end_row_addr  current window range, or freed range during release
//   o_release      one-cycle pulse freeing end-start+1 rows
//   o_busy         high whenever not idle
//   o_done         one-cycle pulse after returning to idle on stop
//   o_error        one-cycle pulse after a rejected configuration
module window_reader #(
    parameter int WIDTH        = 4,
    parameter int POINTER_SIZE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic                    i_stop,
    input  logic [POINTER_SIZE-1:0] i_win_len,
    input  logic [POINTER_SIZE-1:0] i_stride,
    input  logic [WIDTH-1:0]        i_valid_count,
    input  logic                    i_read_ready,
    output logic [POINTER_SIZE-1:0] o_rd_addr,
    output logic                    o_rd_valid,
    output logic [POINTER_SIZE-1:0] o_start_row_addr,
    output logic [POINTER_SIZE-1:0] o_end_row_addr,
    output logic                    o_release,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_RELEASE} state_t;
    state_t                  r_state, w_next;
    logic [POINTER_SIZE-1:0] r_base, r_rd_addr, r_win_len, r_stride, r_beats;
    logic                    r_stop, r_done, r_error;
    logic                    w_bad, w_enough, w_accept, w_last, w_stop;
    assign w_bad    = (i_win_len == '0) || (i_stride == '0) || (i_stride > i_win_len);
    // both operands zero-extended to a common width so the parameters may differ
    assign w_enough = {{POINTER_SIZE{1'b0}}, i_valid_count} >= {{WIDTH{1'b0}}, r_win_len};
    assign w_accept = (r_state == S_READ) && i_read_ready;
    assign w_last   = w_accept && (r_beats == r_win_len - POINTER_SIZE'(1));
    assign w_stop   = r_stop | i_stop;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = (i_start && !w_bad) ? S_WAIT : S_IDLE;
            S_WAIT:    w_next = w_stop ? S_IDLE : (w_enough ? S_READ : S_WAIT);
            S_READ:    w_next = w_last ? S_RELEASE : S_READ;
            S_RELEASE: w_next = w_stop ? S_IDLE : S_WAIT;
            default:   w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base    <= '0;
            r_rd_addr <= '0;
            // a window length of 1 makes the idle end row equal base, i.e. 0 after reset
            r_win_len <= POINTER_SIZE'(1);
            r_stride  <= POINTER_SIZE'(1);
            r_beats   <= '0;
            r_stop    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done  <= (r_state == S_WAIT || r_state == S_RELEASE) && w_next == S_IDLE;
            r_error <= (r_state == S_IDLE) && i_start && w_bad;
            r_stop  <= (r_state == S_IDLE) ? 1'b0 : w_stop;
            if (r_state == S_IDLE && i_start) begin
                r_win_len <= i_win_len;
                r_stride  <= i_stride;
            end
            if (r_state != S_READ && w_next == S_READ) r_rd_addr <= r_base;
            else if (w_accept) r_rd_addr <= r_rd_addr + POINTER_SIZE'(1);
            r_beats <= w_accept ? r_beats + POINTER_SIZE'(1) : ((r_state == S_READ) ? r_beats : '0);
            if (r_state == S_RELEASE) r_base <= r_base + r_stride;
        end
    end
    always_comb begin
        o_rd_valid       = (r_state == S_READ);
        o_release        = (r_state == S_RELEASE);
        o_busy           = (r_state != S_IDLE);
        o_rd_addr        = r_rd_addr;
        o_start_row_addr = r_base;
        o_end_row_addr   = r_base + ((r_state == S_RELEASE) ? r_stride : r_win_len) - POINTER_SIZE'(1);
        o_done           = r_done;
        o_error          = r_error;
    end
endmodule

// File: tb/tb_window_reader.sv
// tb_window_reader: randomized window-level checks of window_reader against a base/config model.
module tb_window_reader;
    localparam int DEPTH = 16;
    logic       clk, rst, i_start, i_stop, i_read_ready;
    logic [3:0] i_win_len, i_stride, i_valid_count;
    logic [3:0] o_rd_addr, o_start_row_addr, o_end_row_addr;
    logic       o_rd_valid, o_release, o_busy, o_done, o_error;
    int n_checks = 0, n_fail = 0;
    int m_base = 0, m_wl = 1, m_st = 1;
    bit m_idle = 1;

    window_reader #(.WIDTH(4), .POINTER_SIZE(4)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop),
        .i_win_len(i_win_len), .i_stride(i_stride), .i_valid_count(i_valid_count),
        .i_read_ready(i_read_ready), .o_rd_addr(o_rd_addr), .o_rd_valid(o_rd_valid),
        .o_start_row_addr(o_start_row_addr), .o_end_row_addr(o_end_row_addr),
        .o_release(o_release), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_rd_valid"}, o_rd_valid, 0);
        check({tag, "_rd_addr"}, o_rd_addr, 0);
        check({tag, "_release"}, o_release, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_error"}, o_error, 0);
        check({tag, "_start_row"}, o_start_row_addr, 0);
        check({tag, "_end_row"}, o_end_row_addr, 0);
    endtask

    task automatic do_start(input int wl, input int st);
        bit bad = (wl == 0) || (st == 0) || (st > wl);
        bit was_idle = m_idle;
        i_valid_count = 0;
        i_win_len = 4'(wl);
        i_stride = 4'(st);
        i_start = 1;
        step();
        i_start = 0;
        if (!was_idle) begin
            check("ignored_start_err", o_error, 0);
            check("ignored_start_busy", o_busy, 1);
        end else if (bad) begin
            check("bad_cfg_err", o_error, 1);
            check("bad_cfg_busy", o_busy, 0);
            step();
            check("bad_cfg_err_pulse", o_error, 0);
            check("bad_cfg_busy2", o_busy, 0);
        end else begin
            m_wl = wl;
            m_st = st;
            m_idle = 0;
            check("start_busy", o_busy, 1);
            check("start_wait_rdv", o_rd_valid, 0);
            check("wait_start_row", o_start_row_addr, m_base);
            check("wait_end_row", o_end_row_addr, (m_base + m_wl - 1) % DEPTH);
        end
    endtask

    task automatic stop_in_wait();
        i_valid_count = 0;
        i_stop = 1;
        step();
        i_stop = 0;
        check("wait_stop_busy", o_busy, 0);
        check("wait_stop_done", o_done, 1);
        check("wait_stop_no_rel", o_release, 0);
        m_idle = 1;
        step();
        check("wait_stop_done_pulse", o_done, 0);
    endtask

    // One full window from WAIT: optional starvation, beats with backpressure, release, slide.
    task automatic run_window(input bit rnd, input logic [15:0] pat, input int stop_beat, input bit starve);
        int k = 0;
        int c = 0;
        bit r;
        bit stopping = (stop_beat >= 0) && (stop_beat < m_wl);
        if (starve) begin
            i_valid_count = 4'(m_wl - 1);
            repeat (3) begin
                step();
                check("starve_rdv", o_rd_valid, 0);
                check("starve_busy", o_busy, 1);
            end
        end
        i_valid_count = 4'($urandom_range(m_wl, 15));
        step();
        while (k < m_wl && c < 100) begin
            check("rd_valid", o_rd_valid, 1);
            check("rd_addr", o_rd_addr, (m_base + k) % DEPTH);
            check("read_no_release", o_release, 0);
            r = rnd ? 1'($urandom_range(0, 1)) : pat[c % 16];
            c++;
            i_read_ready = r;
            i_stop = r && (k == stop_beat);
            step();
            i_stop = 0;
            if (r) k++;
        end
        check("beats_accepted", k, m_wl);
        i_read_ready = 0;
        check("release", o_release, 1);
        check("rel_start_row", o_start_row_addr, m_base);
        check("rel_end_row", o_end_row_addr, (m_base + m_st - 1) % DEPTH);
        check("rel_rdv", o_rd_valid, 0);
        step();
        m_base = (m_base + m_st) % DEPTH;
        check("release_pulse", o_release, 0);
        if (stopping) begin
            check("stop_idle", o_busy, 0);
            check("stop_done", o_done, 1);
            m_idle = 1;
            step();
            check("stop_done_pulse", o_done, 0);
        end else begin
            check("next_wait_busy", o_busy, 1);
            check("next_wait_done", o_done, 0);
            check("next_start_row", o_start_row_addr, m_base);
            check("next_end_row", o_end_row_addr, (m_base + m_wl - 1) % DEPTH);
        end
        i_valid_count = 0;
    endtask

    initial begin
        rst = 0;
        i_start = 0;
        i_stop = 0;
        i_win_len = 0;
        i_stride = 0;
        i_valid_count = 0;
        i_read_ready = 0;
        step();
        step();
        check_reset_outputs("reset");
        rst = 1;
        // basic window: 0,1,2 then 1,2,3
        do_start(3, 1);
        run_window(0, 16'hFFFF, -1, 0);
        run_window(0, 16'hFFFF, -1, 0);
        // starvation hold then read
        run_window(0, 16'hFFFF, -1, 1);
        // reach base 14, then wrap window 14,15,0,1
        stop_in_wait();
        do_start(11, 11);
        run_window(1, 16'h0, -1, 0);
        check("base_14", m_base, 14);
        stop_in_wait();
        do_start(4, 4);
        run_window(0, 16'hFFFF, -1, 0);
        // start while busy is ignored
        do_start(2, 4);
        stop_in_wait();
        // bad configuration
        do_start(2, 4);
        do_start(0, 0);
        // backpressure 1,0,0,1,1 with stop on second beat
        do_start(3, 3);
        run_window(0, 16'hFFF9, 1, 0);
        // reset mid-READ at row 5
        do_start(4, 1);
        i_valid_count = 15;
        step();
        check("pre_reset_rdv", o_rd_valid, 1);
        check("pre_reset_addr", o_rd_addr, 5);
        i_read_ready = 1;
        rst = 0;
        #1;
        check_reset_outputs("async_reset");
        step();
        check_reset_outputs("held_reset");
        rst = 1;
        i_read_ready = 0;
        m_base = 0;
        m_idle = 1;
        do_start(3, 1);
        run_window(0, 16'hFFFF, -1, 0);
        // randomized mix
        for (int i = 0; i < 40; i++) begin
            if (m_idle) begin
                int wl = $urandom_range(0, 15);
                int st = ($urandom_range(0, 3) == 0 || wl == 0) ? $urandom_range(0, 15) : $urandom_range(1, wl);
                do_start(wl, st);
            end else if ($urandom_range(0, 7) == 0) begin
                do_start($urandom_range(0, 15), $urandom_range(0, 15));
            end else if ($urandom_range(0, 5) == 0) begin
                stop_in_wait();
            end else begin
                run_window(1, 16'h0,
                           ($urandom_range(0, 3) == 0) ? $urandom_range(0, m_wl - 1) : -1,
                           $urandom_range(0, 3) == 0);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
